tsf_timer_cmp: RTL and testbench

//  Parametrised 802.11 TSF timer with signed drift adjust and NUM_CMP compare channels.

---
 rtl/tsf_pkg.sv | 22 ++
 rtl/tsf_cmp_chan.sv | 53 +++++
 rtl/tsf_timer_cmp.sv | 86 ++++++++
 tb/tb_tsf_timer_cmp.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsf_pkg.sv
// Shared definitions for the TSF timer: default width, compare-channel states and
// the sign-extension helper for the drift adjust value.
package tsf_pkg;

  localparam int unsigned TSF_W = 64;

  typedef enum logic {
    CmpIdle  = 1'b0,
    CmpArmed = 1'b1
  } cmp_state_e;

  // Sign-extend the low adj_w bits of raw to the full TSF width.
  function automatic logic [TSF_W-1:0] sext_adj(input logic [TSF_W-1:0] raw,
                                                input int unsigned    adj_w);
    int unsigned sh;
    logic signed [TSF_W-1:0] tmp;
    sh  = TSF_W - adj_w;
    tmp = raw << sh;
    return tmp >>> sh;
  endfunction

endpackage

// File: rtl/tsf_cmp_chan.sv
// One TSF compare channel: latched target, IDLE/ARMED state and an unsigned >= check
// against the registered TSF, producing a single-cycle hit pulse.
module tsf_cmp_chan
  import tsf_pkg::*;
#(
  parameter int unsigned W = TSF_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         arm,
  input  logic         disarm,
  input  logic [W-1:0] target,
  input  logic [W-1:0] tsf,
  output logic         armed,
  output logic         hit
);

  cmp_state_e   state_q, state_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic         hit_q, hit_d;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    hit_d   = 1'b0;
    // Disarm wins over arm; a re-arm drops any hit that would otherwise fire now.
    if (disarm) begin
      state_d = CmpIdle;
    end else if (arm) begin
      state_d = CmpArmed;
      tgt_d   = target;
    end else if (state_q == CmpArmed && tsf >= tgt_q) begin
      state_d = CmpIdle;
      hit_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CmpIdle;
      tgt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
    end
  end

  assign armed = (state_q == CmpArmed);
  assign hit   = hit_q;

endmodule

// File: rtl/tsf_timer_cmp.sv
// 802.11 TSF timer: microsecond prescaler, falling-edge load, signed drift adjust and
// NUM_CMP independent compare channels.
module tsf_timer_cmp
  import tsf_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = TSF_W,
  parameter int unsigned CLK_DIV     = 100,
  parameter int unsigned NUM_CMP     = 4,
  parameter int unsigned ADJ_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           tsf_load_control,
  input  logic [TIMER_WIDTH-1:0]         tsf_load_val,
  input  logic                           tsf_adj_valid,
  input  logic [ADJ_WIDTH-1:0]           tsf_adj_val,
  input  logic [NUM_CMP-1:0]             cmp_arm,
  input  logic [NUM_CMP-1:0]             cmp_disarm,
  input  logic [NUM_CMP*TIMER_WIDTH-1:0] cmp_target,
  output logic [TIMER_WIDTH-1:0]         tsf_runtime_val,
  output logic                           tsf_pulse_1M,
  output logic [NUM_CMP-1:0]             cmp_armed,
  output logic [NUM_CMP-1:0]             cmp_hit
);

  localparam int unsigned PSC_W = 16;

  logic [PSC_W-1:0]       psc_q, psc_d;
  logic [TIMER_WIDTH-1:0] tsf_q, tsf_d;
  logic                   pulse_q, pulse_d;
  logic                   ctl_q;
  logic                   tick;
  logic                   load;
  logic [TSF_W-1:0]       adj_ext;
  logic [TIMER_WIDTH-1:0] adj_add;

  assign tick    = (psc_q == PSC_W'(CLK_DIV - 1));
  assign load    = ~tsf_load_control & ctl_q;
  assign adj_ext = sext_adj(TSF_W'(tsf_adj_val), ADJ_WIDTH);
  assign adj_add = tsf_adj_valid ? TIMER_WIDTH'(adj_ext) : '0;

  always_comb begin
    psc_d   = tick ? '0 : psc_q + PSC_W'(1);
    pulse_d = tick;
    tsf_d   = tsf_q + adj_add + TIMER_WIDTH'(tick);
    // A load restarts the microsecond phase and swallows any tick or adjust.
    if (load) begin
      tsf_d   = tsf_load_val;
      psc_d   = '0;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc_q   <= '0;
      tsf_q   <= '0;
      pulse_q <= 1'b0;
      ctl_q   <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      tsf_q   <= tsf_d;
      pulse_q <= pulse_d;
      ctl_q   <= tsf_load_control;
    end
  end

  assign tsf_runtime_val = tsf_q;
  assign tsf_pulse_1M    = pulse_q;

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_chan
    tsf_cmp_chan #(
      .W (TIMER_WIDTH)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .arm    (cmp_arm[i]),
      .disarm (cmp_disarm[i]),
      .target (cmp_target[i*TIMER_WIDTH +: TIMER_WIDTH]),
      .tsf    (tsf_q),
      .armed  (cmp_armed[i]),
      .hit    (cmp_hit[i])
    );
  end

endmodule

// File: tb/tb_tsf_timer_cmp.sv
// Directed bench for tsf_timer_cmp with a behavioural reference model checked every cycle.
module tb_tsf_timer_cmp;

  localparam int unsigned W   = 64;
  localparam int unsigned DIV = 4;
  localparam int unsigned NC  = 4;
  localparam int unsigned AW  = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            tsf_load_control = 1'b0;
  logic [W-1:0]    tsf_load_val = '0;
  logic            tsf_adj_valid = 1'b0;
  logic [AW-1:0]   tsf_adj_val = '0;
  logic [NC-1:0]   cmp_arm = '0;
  logic [NC-1:0]   cmp_disarm = '0;
  logic [NC*W-1:0] cmp_target = '0;
  logic [W-1:0]    tsf_runtime_val;
  logic            tsf_pulse_1M;
  logic [NC-1:0]   cmp_armed;
  logic [NC-1:0]   cmp_hit;

  always #5 clk = ~clk;

  tsf_timer_cmp #(
    .TIMER_WIDTH (W),
    .CLK_DIV     (DIV),
    .NUM_CMP     (NC),
    .ADJ_WIDTH   (AW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .tsf_load_control (tsf_load_control),
    .tsf_load_val     (tsf_load_val),
    .tsf_adj_valid    (tsf_adj_valid),
    .tsf_adj_val      (tsf_adj_val),
    .cmp_arm          (cmp_arm),
    .cmp_disarm       (cmp_disarm),
    .cmp_target       (cmp_target),
    .tsf_runtime_val  (tsf_runtime_val),
    .tsf_pulse_1M     (tsf_pulse_1M),
    .cmp_armed        (cmp_armed),
    .cmp_hit          (cmp_hit)
  );

  // Reference model: microsecond phase as a modulo counter, TSF as plain arithmetic.
  logic [W-1:0]  m_tsf;
  int unsigned   m_phase;
  logic          m_pulse;
  logic          m_ctl;
  logic [NC-1:0] m_armed;
  logic [NC-1:0] m_hit;
  logic [W-1:0]  m_tgt [NC];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tsf   <= '0;
      m_phase <= 0;
      m_pulse <= 1'b0;
      m_ctl   <= 1'b0;
      m_armed <= '0;
      m_hit   <= '0;
      for (int i = 0; i < NC; i++) m_tgt[i] <= '0;
    end else begin
      m_ctl <= tsf_load_control;
      if (!tsf_load_control && m_ctl) begin
        m_tsf   <= tsf_load_val;
        m_phase <= 0;
        m_pulse <= 1'b0;
      end else begin
        m_phase <= (m_phase + 1) % DIV;
        m_pulse <= (m_phase == DIV - 1);
        m_tsf   <= m_tsf + (tsf_adj_valid ? {{(W-AW){tsf_adj_val[AW-1]}}, tsf_adj_val} : '0)
                   + W'(m_phase == DIV - 1);
      end
      for (int i = 0; i < NC; i++) begin
        m_hit[i] <= 1'b0;
        if (cmp_disarm[i]) begin
          m_armed[i] <= 1'b0;
        end else if (cmp_arm[i]) begin
          m_armed[i] <= 1'b1;
          m_tgt[i]   <= cmp_target[i*W +: W];
        end else if (m_armed[i] && m_tsf >= m_tgt[i]) begin
          m_armed[i] <= 1'b0;
          m_hit[i]   <= 1'b1;
        end
      end
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare against the model on the falling edge, then advance one clock.
  task automatic step();
    @(negedge clk);
    chk("model_tsf", tsf_runtime_val, m_tsf);
    chk("model_pulse", W'(tsf_pulse_1M), W'(m_pulse));
    chk("model_armed", W'(cmp_armed), W'(m_armed));
    chk("model_hit", W'(cmp_hit), W'(m_hit));
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input logic [W-1:0] v);
    tsf_load_control = 1'b1;
    step();
    tsf_load_control = 1'b0;
    tsf_load_val     = v;
    step();
  endtask

  task automatic wait_tsf(input logic [W-1:0] v);
    int k;
    k = 0;
    while (tsf_runtime_val != v && k < 400) begin
      step();
      k++;
    end
    if (tsf_runtime_val != v) chk("wait_tsf_timeout", tsf_runtime_val, v);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tsf", tsf_runtime_val, 64'd0);
    chk("reset_pulse", W'(tsf_pulse_1M), 64'd0);
    chk("reset_armed", W'(cmp_armed), 64'd0);
    chk("reset_hit", W'(cmp_hit), 64'd0);
    step();
    rstn = 1'b1;

    // Free run: 40 clocks at 4 clocks/us.
    steps(40);
    chk("run40_tsf", tsf_runtime_val, 64'd10);
    chk("run40_pulse", W'(tsf_pulse_1M), 64'd1);

    // Load coinciding with a tick.
    tsf_load_control = 1'b1;
    steps(3);
    tsf_load_control = 1'b0;
    tsf_load_val     = 64'h1234_0000_0000_0000;
    step();
    chk("load_tsf", tsf_runtime_val, 64'h1234_0000_0000_0000);
    chk("load_no_pulse", W'(tsf_pulse_1M), 64'd0);
    steps(3);
    chk("load_hold", tsf_runtime_val, 64'h1234_0000_0000_0000);
    step();
    chk("load_first_inc", tsf_runtime_val, 64'h1234_0000_0000_0001);
    chk("load_first_pulse", W'(tsf_pulse_1M), 64'd1);

    // Adjust -5 on a tick cycle, +7 off tick, wrap at the top.
    load(64'd100);
    steps(3);
    tsf_adj_valid = 1'b1;
    tsf_adj_val   = 16'hFFFB;
    step();
    tsf_adj_valid = 1'b0;
    chk("adj_neg_tick", tsf_runtime_val, 64'd96);
    chk("adj_neg_pulse", W'(tsf_pulse_1M), 64'd1);
    load(64'd100);
    tsf_adj_valid = 1'b1;
    tsf_adj_val   = 16'd7;
    step();
    tsf_adj_valid = 1'b0;
    chk("adj_pos", tsf_runtime_val, 64'd107);
    chk("adj_pos_pulse", W'(tsf_pulse_1M), 64'd0);
    load('1);
    tsf_adj_valid = 1'b1;
    tsf_adj_val   = 16'd1;
    step();
    tsf_adj_valid = 1'b0;
    chk("adj_wrap", tsf_runtime_val, 64'd0);

    // ch0 future target.
    load(64'd45);
    cmp_arm             = 4'b0001;
    cmp_target[0 +: W]  = 64'd50;
    step();
    cmp_arm = '0;
    chk("ch0_armed", W'(cmp_armed[0]), 64'd1);
    wait_tsf(64'd50);
    chk("ch0_not_yet", W'(cmp_hit[0]), 64'd0);
    step();
    chk("ch0_hit", W'(cmp_hit[0]), 64'd1);
    chk("ch0_disarmed", W'(cmp_armed[0]), 64'd0);
    step();
    chk("ch0_single", W'(cmp_hit[0]), 64'd0);

    // ch1 target already past.
    load(64'd20);
    cmp_arm             = 4'b0010;
    cmp_target[W +: W]  = 64'd10;
    step();
    cmp_arm = '0;
    chk("ch1_armed", W'(cmp_armed[1]), 64'd1);
    chk("ch1_no_early", W'(cmp_hit[1]), 64'd0);
    step();
    chk("ch1_hit", W'(cmp_hit), 64'b0010);

    // ch2 armed, then TSF loaded below the target.
    load(64'd25);
    cmp_arm              = 4'b0100;
    cmp_target[2*W +: W] = 64'd30;
    step();
    cmp_arm = '0;
    load(64'd5);
    chk("ch2_reload", tsf_runtime_val, 64'd5);
    chk("ch2_still_armed", W'(cmp_armed), 64'b0100);
    wait_tsf(64'd30);
    chk("ch2_not_yet", W'(cmp_hit), 64'd0);
    step();
    chk("ch2_hit", W'(cmp_hit), 64'b0100);

    // Simultaneous arm and disarm on ch3.
    cmp_arm              = 4'b1000;
    cmp_disarm           = 4'b1000;
    cmp_target[3*W +: W] = 64'd0;
    step();
    cmp_arm    = '0;
    cmp_disarm = '0;
    chk("ch3_idle", W'(cmp_armed), 64'd0);
    step();
    chk("ch3_no_hit", W'(cmp_hit), 64'd0);

    // Asynchronous reset while ch0 is armed.
    cmp_arm            = 4'b0001;
    cmp_target[0 +: W] = tsf_runtime_val + 64'd2;
    step();
    cmp_arm = '0;
    chk("rst_pre_armed", W'(cmp_armed), 64'b0001);
    rstn = 1'b0;
    #1;
    chk("rst_async_tsf", tsf_runtime_val, 64'd0);
    chk("rst_async_pulse", W'(tsf_pulse_1M), 64'd0);
    chk("rst_async_armed", W'(cmp_armed), 64'd0);
    chk("rst_async_hit", W'(cmp_hit), 64'd0);
    step();
    rstn = 1'b1;
    steps(12);
    chk("rst_rerun_tsf", tsf_runtime_val, 64'd3);
    steps(40);
    chk("rst_no_hit", W'(cmp_hit), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
